// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: mode codes, FSM states,
// and a helper that classifies a mode by shift direction.
package shifter_pkg;

  localparam logic [2:0] SHL0 = 3'b000;
  localparam logic [2:0] SHL1 = 3'b001;
  localparam logic [2:0] SHR0 = 3'b010;
  localparam logic [2:0] SHR1 = 3'b011;
  localparam logic [2:0] SAL  = 3'b100;
  localparam logic [2:0] SAR  = 3'b101;
  localparam logic [2:0] ROL  = 3'b110;
  localparam logic [2:0] ROR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Left-moving modes take their carry from the MSB, right-moving ones from the LSB.
  function automatic logic is_left(input logic [2:0] mode);
    return (mode == SHL0) || (mode == SHL1) || (mode == SAL) || (mode == ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate step: (q, m) -> (q_next, co_next).
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       m,
  output logic [WIDTH-1:0] q_next,
  output logic             co_next
);

  // Apply a single step of the selected mode and pick the bit that falls out.
  always_comb begin
    q_next  = q;
    co_next = 1'b0;
    case (m)
      SHL0, SAL: q_next = {q[WIDTH-2:0], 1'b0};
      SHL1:      q_next = {q[WIDTH-2:0], 1'b1};
      SHR0:      q_next = {1'b0, q[WIDTH-1:1]};
      SHR1:      q_next = {1'b1, q[WIDTH-1:1]};
      SAR:       q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      ROL:       q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      ROR:       q_next = {q[0], q[WIDTH-1:1]};
      default:   q_next = q;
    endcase
    co_next = is_left(m) ? q[WIDTH-1] : q[0];
  end

endmodule

// File: rtl/shifter_seq.sv
// Iterative shifter: accepts (a, m, amt), shifts one position per clock,
// then presents (r, co) until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and r/co are held stable while out_valid waits for out_ready.
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       m,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             co,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       m_q, m_d;

  logic [WIDTH-1:0] step_q;
  logic             step_co;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (q_q),
    .m       (m_q),
    .q_next  (step_q),
    .co_next (step_co)
  );

  // Next-state logic: load on accept, step while counting down, release on take.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d     = a;
          m_d     = m;
          cnt_d   = amt;
          co_d    = 1'b0;
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        q_d   = step_q;
        co_d  = step_co;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
      m_q     <= SHL0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign r         = q_q;
  assign co        = co_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Bench for shifter_seq: behavioural reference model, per-cycle compare,
// literal directed cases, backpressure, mid-operation reset, random traffic.
module tb_shifter_seq;
  import shifter_pkg::*;

  localparam int W     = 4;
  localparam int AMT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [2:0]       m = '0;
  logic [AMT_W-1:0] amt = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     r;
  logic             co;
  state_e           dbg_state;

  shifter_seq #(.WIDTH(W), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .m         (m),
    .amt       (amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .co        (co),
    .dbg_state (dbg_state)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Whole-operation result from the mode rules: {co, r}.
  function automatic logic [W:0] model_op(input logic [W-1:0] av, input logic [2:0] mv, input int n);
    logic [W-1:0] res;
    logic [W-1:0] lo_mask;
    logic [W-1:0] hi_mask;
    logic         c;
    logic         f;
    int           k;
    res = av;
    c   = 1'b0;
    f   = 1'b0;
    for (int i = 0; i < W; i++) begin
      lo_mask[i] = (i < n);
      hi_mask[i] = (i >= W - n);
    end
    if (n == 0) return {1'b0, av};
    k = n % W;
    case (mv)
      SHL0, SHL1, SAL: begin
        f   = (mv == SHL1);
        res = (n >= W) ? {W{f}} : ((av << n) | (f ? lo_mask : '0));
        c   = (n <= W) ? av[W-n] : f;
      end
      SHR0, SHR1, SAR: begin
        f   = (mv == SHR1) ? 1'b1 : ((mv == SAR) ? av[W-1] : 1'b0);
        res = (n >= W) ? {W{f}} : ((av >> n) | (f ? hi_mask : '0));
        c   = (n <= W) ? av[n-1] : f;
      end
      ROL: begin
        res = (k == 0) ? av : ((av << k) | (av >> (W - k)));
        c   = res[0];
      end
      default: begin
        res = (k == 0) ? av : ((av >> k) | (av << (W - k)));
        c   = res[W-1];
      end
    endcase
    return {c, res};
  endfunction

  // Transaction-level timing: result visible after edge (accept edge + amt),
  // gone after the handshake edge; requests accepted only while none is pending.
  logic [W:0] exp_q[$];
  int  cyc   = 0;
  bit  pend  = 0;
  int  due   = 0;
  int  n_acc = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend = 0;
        exp_q.delete();
      end else begin
        if (pend && cyc >= due && out_ready) begin
          pend = 0;
          void'(exp_q.pop_front());
        end else if (!pend && in_valid) begin
          pend = 1;
          due  = cyc + 1 + int'(amt);
          exp_q.push_back(model_op(a, m, int'(amt)));
          n_acc++;
        end
        cyc++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      exp_v = pend && (cyc >= due);
      check("in_ready", 32'(in_ready), 32'(!pend));
      check("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v && exp_q.size() > 0) begin
        check("r", 32'(r), 32'(exp_q[0][W-1:0]));
        check("co", 32'(co), 32'(exp_q[0][W]));
      end
    end
  end

  // ---------------- drivers ----------------
  bit ready_rand = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [2:0] mv, input logic [AMT_W-1:0] nv);
    int start;
    int t;
    start = n_acc;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    m = mv;
    amt = nv;
    while (n_acc == start && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (n_acc == start) begin
      n_err++;
      $display("FAIL accept_timeout at %0t: got no accept expected accept", $time);
    end
    in_valid = 1'b0;
    a   = W'($urandom_range(0, 2**W - 1));
    m   = 3'($urandom_range(0, 7));
    amt = AMT_W'($urandom_range(0, 2**AMT_W - 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic lit(input string name, input logic [W-1:0] av, input logic [2:0] mv,
                     input logic [AMT_W-1:0] nv, input logic [W-1:0] er, input logic ec);
    logic [W:0] mo;
    int lat;
    mo = model_op(av, mv, int'(nv));
    check({name, "_model_r"}, 32'(mo[W-1:0]), 32'(er));
    check({name, "_model_co"}, 32'(mo[W]), 32'(ec));
    out_ready = 1'b0;
    send(av, mv, nv);
    wait_valid(lat);
    check({name, "_latency"}, 32'(lat), 32'(nv));
    check({name, "_r"}, 32'(r), 32'(er));
    check({name, "_co"}, 32'(co), 32'(ec));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int t;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    lit("t1_sar", 4'b1001, SAR,  3'd1, 4'b1100, 1'b1);
    lit("t2_rol", 4'b1001, ROL,  3'd5, 4'b0011, 1'b1);
    lit("t3_shr1", 4'b0111, SHR1, 3'd3, 4'b1110, 1'b1);
    lit("t4_shl0", 4'b1111, SHL0, 3'd4, 4'b0000, 1'b1);
    lit("t5_amt0", 4'b1010, ROL,  3'd0, 4'b1010, 1'b0);
    lit("sal7", 4'b1000, SAL,  3'd7, 4'b0000, 1'b0);
    lit("ror6", 4'b0001, ROR,  3'd6, 4'b0100, 1'b0);

    // Backpressure: result held while a new request waits at the input.
    send(4'b1011, SHL0, 3'd1);
    wait_valid(lat);
    in_valid = 1'b1;
    a = 4'b0101;
    m = ROR;
    amt = 3'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_r", 32'(r), 32'b0110);
      check("bp_co", 32'(co), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_after_hs_in_ready", 32'(in_ready), 32'd1);
    check("bp_after_hs_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("bp_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_new_r", 32'(r), 32'b1010);
    check("bp_new_co", 32'(co), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a long operation.
    send(4'b1111, SHR0, 3'd7);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_r", 32'(r), 32'd0);
    check("mid_rst_co", 32'(co), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Random traffic with random consumer backpressure.
    ready_rand = 1;
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom_range(0, 2**W - 1)), 3'($urandom_range(0, 7)),
           AMT_W'($urandom_range(0, 2**AMT_W - 1)));
    end
    t = 0;
    while (pend && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (pend) begin
      n_err++;
      $display("FAIL drain_timeout at %0t: got pending expected drained", $time);
    end
    ready_rand = 0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout at %0t: got running expected finished", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shifter_seq.md
# shifter_seq

Iterative, handshaked counterpart to the combinational 4-bit `shifter`. It accepts an operand, a 3-bit mode and a shift amount, then shifts one bit position per clock using the same mode encoding. It returns the result and the last bit shifted out over a valid/ready output port. It sits behind the datapath's request bus and serves multi-position shifts that the single-step `shifter` cannot do in one pass.

## Interface
- `WIDTH`, 4, operand/result width (≥2)
- `AMT_W`, 3, shift-amount width; amounts 0..2^AMT_W−1
- `clk` in 1, sole clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `in_valid` in 1, request present
- `in_ready` out 1, block can accept a request
- `a` in WIDTH, operand
- `m` in 3, mode (encoding below)
- `amt` in AMT_W, number of single-bit steps
- `out_valid` out 1, result present
- `out_ready` in 1, consumer takes result
- `r` out WIDTH, result
- `co` out 1, last bit shifted or rotated out (0 if amt=0)
- One clock; reset is asynchronous and active-low.

## Operation
- Mode, applied per step to register `q`:
  - 000: shl, fill 0
  - 001: shl, fill 1
  - 010: shr, fill 0
  - 011: shr, fill 1
  - 100: sal, fill 0
  - 101: sar, fill q[W−1]
  - 110: rol
  - 111: ror
- Step carry:
  - left modes (000, 001, 100, 110): step co = q[W−1]
  - right modes (010, 011, 101, 111): step co = q[0]
- FSM states IDLE, SHIFT, DONE; reset → IDLE.
- IDLE:
  - `in_ready`=1.
  - On in_valid: load q←a, latch m, cnt←amt, co←0.
  - Next state is DONE if amt=0, else SHIFT.
- SHIFT:
  - Each edge: q←step(q), co←step co, cnt←cnt−1.
  - When cnt=1 at the edge, go to DONE.
- DONE:
  - `out_valid`=1; `r`=q and `co` are held stable.
  - On out_ready: go to IDLE.
- `in_ready` is high only in IDLE. Requests in SHIFT or DONE are not accepted; the source must hold them.
- Mode and amount are sampled only at accept. Input changes afterward have no effect.
- Amounts ≥ WIDTH are legal:
  - Shifts saturate to the fill pattern.
  - Rotates wrap (amt mod WIDTH positions).
  - co follows the stepwise definition.
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `r`=0, `co`=0, cnt=0.
- Reset asserted mid-SHIFT or in DONE aborts the operation immediately. No result is emitted.

## Timing
- Accept occurs on edge E0, where in_valid & in_ready are both high.
- amt=n>0:
  - Shifts occur on E1..En.
  - `out_valid` rises after En.
  - Latency is n+1 edges from accept to result-visible cycle.
- amt=0: `out_valid` rises after E0.
- Output handshake occurs on the edge where out_valid & out_ready. `in_ready` rises the cycle after.
- Best-case throughput is one request per n+2 cycles.
- Outputs are registered: `r` = q, `co` = co register, `in_ready`/`out_valid` decoded from state. No combinational path from inputs to outputs.

## Structure
- Shared package `shifter_pkg`:
  - mode constants `SHL0`, `SHL1`, `SHR0`, `SHR1`, `SAL`, `SAR`, `ROL`, `ROR` (3-bit)
  - FSM state enum
- Sub-module `shift_step`: combinational one-position step, (q, m) → (q_next, co_next), parameterised by WIDTH. `shifter_seq` instantiates it once.
- Counter, state register and q/co registers live in `shifter_seq`.

## Test plan
- Test 1: a=1001, m=101, amt=1.
  - Expect r=1100, co=1.
  - out_valid is first seen in the cycle after E1.
- Test 2: a=1001, m=110, amt=5.
  - Expect r=0011, co=1 (wrap past WIDTH).
  - out_valid appears after edge E5.
- Test 3: a=0111, m=011, amt=3.
  - Expect r=1110, co=1.
- Test 4: a=1111, m=000, amt=4.
  - Expect r=0000, co=1.
- Test 5: a=1010, m=110, amt=0.
  - Expect r=1010, co=0.
  - out_valid is high in the cycle right after accept.
- Test 6: backpressure and reset.
  - Setup: hold out_ready=0 for 5 cycles in DONE. Meanwhile drive in_valid=1 with a different a.
  - Expect: r and co stay stable, in_ready=0, and the new request is not accepted until the cycle after the out handshake.
  - Then assert rst_n=0 mid-SHIFT. Expect immediately: out_valid=0, in_ready=1, r=0, co=0.
